// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E-stage operand/control bus into the multiply/divide unit
// and the busy/HI/LO read-back toward hazard and mfhi/mflo logic.
interface mdu_hilo_if;
    logic [2:0]  MDUop;
    logic        start;
    logic        req;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output MDUop, start, req, rs, rt,
        input  busy, HI, LO
    );

    modport slave (
        input  MDUop, start, req, rs, rt,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: fixed-latency multiply/divide unit owning the HI/LO registers.
// Results are computed at accept and held until the latency count expires.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_hilo_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic          wr_q, wr_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic busy, done;
    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic valid_op, is_long, accept;

    logic [31:0] rs, rt;
    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo_s, rem_s;
    logic [31:0] rt_safe, quo_u, rem_u;

    assign rs = bus.rs;
    assign rt = bus.rt;

    assign op_mult  = (bus.MDUop == 3'd1);
    assign op_multu = (bus.MDUop == 3'd2);
    assign op_div   = (bus.MDUop == 3'd3);
    assign op_divu  = (bus.MDUop == 3'd4);
    assign op_mthi  = (bus.MDUop == 3'd5);
    assign op_mtlo  = (bus.MDUop == 3'd6);

    assign valid_op = op_mult | op_multu | op_div | op_divu | op_mthi | op_mtlo;
    assign is_long  = op_mult | op_multu | op_div | op_divu;
    assign accept   = (state_q == IDLE) & bus.start & ~bus.req & valid_op;

    // Arithmetic: products take the low 64 bits of extended operands;
    // signed divide works on magnitudes so 0x80000000/-1 wraps naturally.
    always_comb begin
        a_sx    = {{32{rs[31]}}, rs};
        b_sx    = {{32{rt[31]}}, rt};
        prod_s  = a_sx * b_sx;
        prod_u  = {32'd0, rs} * {32'd0, rt};
        a_neg   = rs[31];
        b_neg   = rt[31];
        a_mag   = a_neg ? (~rs + 32'd1) : rs;
        b_mag   = b_neg ? (~rt + 32'd1) : rt;
        b_safe  = (rt == 32'd0) ? 32'd1 : b_mag;
        uq      = a_mag / b_safe;
        ur      = a_mag % b_safe;
        quo_s   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem_s   = a_neg ? (~ur + 32'd1) : ur;
        rt_safe = (rt == 32'd0) ? 32'd1 : rt;
        quo_u   = rs / rt_safe;
        rem_u   = rs % rt_safe;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: long ops enter RUN, leave when the count hits one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && is_long) state_d = RUN;
            RUN:  if (cnt_q == CW'(1))   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == RUN) && (cnt_q == CW'(1));
    end

    // Next values for counter and result holding registers.
    always_comb begin
        cnt_d = cnt_q;
        res_d = res_q;
        wr_d  = wr_q;
        if (accept && is_long) begin
            wr_d = 1'b1;
            unique case (1'b1)
                op_mult:  begin
                    res_d = prod_s;
                    cnt_d = CW'(MULT_CYCLES);
                end
                op_multu: begin
                    res_d = prod_u;
                    cnt_d = CW'(MULT_CYCLES);
                end
                op_div:   begin
                    res_d = {rem_s, quo_s};
                    wr_d  = (rt != 32'd0);
                    cnt_d = CW'(DIV_CYCLES);
                end
                op_divu:  begin
                    res_d = {rem_u, quo_u};
                    wr_d  = (rt != 32'd0);
                    cnt_d = CW'(DIV_CYCLES);
                end
                default: ;
            endcase
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Next HI/LO: retire a finished long op, or move-to on accept.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (done && wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
        end else if (accept && op_mthi) begin
            hi_d = rs;
        end else if (accept && op_mtlo) begin
            lo_d = rs;
        end
    end

    // Datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            res_q <= '0;
            wr_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
            wr_q  <= wr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign bus.busy = busy;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with the architectural HI/LO registers.
- Sits in the E stage alongside the ALU and takes the same forwarded rs/rt operands.
- Executes mult, multu, div, divu, mthi and mtlo with fixed multi-cycle latency.
- Exports busy for the hazard unit, and HI/LO for mfhi/mflo read-out.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1)
DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MDUop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
start  input  1  qualifies MDUop for the current E-stage instruction
req  input  1  exception/interrupt flush; E-stage instruction is cancelled
rs  input  32  operand A (dividend / multiplicand / mthi-mtlo source)
rt  input  32  operand B (divisor / multiplier)
busy  output  1  operation in flight; HI/LO not yet valid
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset value: HI=0, LO=0, busy=0, internal counter=0, result holding registers=0.
- Reset mid-operation: the operation is aborted, HI/LO are cleared, and busy drops at that edge.
- States:
  - IDLE (busy=0): accepts a new operation.
  - RUN (busy=1): counter counts down.
- Accept: at an edge in IDLE with start=1, req=0, reset=0 and MDUop in {1..6}.
- Accept with req=1: the op is ignored entirely; no state change, no HI/LO write.
- mult/multu/div/divu on accept:
  - Compute the 64-bit result from the rs/rt values sampled at that edge into holding registers.
  - Load counter = MULT_CYCLES or DIV_CYCLES and enter RUN.
- RUN:
  - Counter decrements every edge.
  - At the edge where counter==1: write HI/LO from the holding registers, clear busy, return to IDLE.
- Timing: start sampled at edge E means busy=1 in cycles E+1..E+N. New HI/LO and busy=0 are visible after edge E+N.
- start while busy=1: ignored. The stall unit must hold the instruction; this is an assertion target for verification.
- req while busy=1: no effect. An accepted operation always completes.
- mthi/mtlo: single-cycle.
  - At the accepting edge, HI<=rs (mthi) or LO<=rs (mtlo).
  - busy stays 0.
  - The other register is unchanged.
- mult: signed 32x32 -> 64, {HI,LO}=$signed(rs)*$signed(rt).
- multu: unsigned 32x32 -> 64.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- div overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (div/divu, rt==0):
  - Full DIV_CYCLES busy period.
  - HI/LO retain their previous values at completion.
  - No exception is raised.
- HI/LO outputs are registered and change only at edges. A read in the same cycle as an mthi/mtlo accept returns the old value; the forwarding path is external.
- MDUop=0/7 with start=1: no action.

Test Plan:
- Reset with HI/LO nonzero, reset=1 for one edge -> HI=0, LO=0, busy=0 next cycle.
- mult rs=0xFFFFFFFD(-3), rt=7:
  - busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - HI/LO unchanged while busy.
- multu rs=rt=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Division cases, 10 busy cycles each:
  - div rs=0xFFFFFFF9(-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu rs=7, rt=2 -> LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div by zero with HI=0x11, LO=0x22 -> busy 10 cycles, then HI=0x11, LO=0x22.
- Flush, abort and stall cases:
  - mthi rs=0xABCD with req=1 -> HI unchanged.
  - mthi with req=0 -> HI=0xABCD next edge, busy=0.
  - reset asserted in the 3rd busy cycle of a div -> busy=0, HI=LO=0, no late write.
  - start asserted while busy -> ignored.
